// File: rtl/fpu_wb_buffer.sv
// FPU-to-GPR writeback queue: holds FPU results bound for integer rd and drains the
// head whenever neither ALU nor CSR writeback owns the port. Head visible one cycle after push.
module fpu_wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        flush,
  input  logic        fpu_result_valid,
  input  logic [31:0] fpu_result_data,
  input  logic [4:0]  fpu_result_rd,
  input  logic        alu_wb_active,
  input  logic        csr_wb_active,
  output logic        fpu_complete_rd,
  output logic [31:0] fpu_result_rd_w,
  output logic [4:0]  fpu_rd_addr,
  output logic        fpu_wb_ready,
  output logic [31:0] rd_busy,
  output logic [3:0]  occupancy,
  output logic        overflow_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [31:0]   data_q [DEPTH];
  logic [4:0]    rd_q   [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [3:0]    count_q, count_d, count_vis;
  logic          ovf_q, ovf_d;
  logic          port_free, pop, push_req, push;
  logic [PW-1:0] rel;

  always_comb begin
    port_free = ~alu_wb_active & ~csr_wb_active;
    // Outputs read as empty while reset is held so a mid-stall reset never emits a write.
    count_vis = rst_l ? 4'd0 : count_q;
    fpu_complete_rd = (count_vis != 4'd0) & port_free & ~flush;
    pop      = fpu_complete_rd;
    push_req = fpu_result_valid & (fpu_result_rd != 5'd0) & ~flush;
    push     = push_req & ((count_q < DEPTH_C) | pop);

    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (push_req & ~push);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    fpu_result_rd_w = (count_vis != 4'd0) ? data_q[head_q] : 32'd0;
    fpu_rd_addr     = (count_vis != 4'd0) ? rd_q[head_q]   : 5'd0;
    fpu_wb_ready    = (count_vis < DEPTH_C);
    occupancy       = count_vis;
    overflow_err    = ovf_q;

    rd_busy = '0;
    rel     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Entry i is live when its distance from head is below the count.
      rel = PW'(i) - head_q;
      if (4'(rel) < count_vis) rd_busy[rd_q[i]] = 1'b1;
    end
    rd_busy[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_l) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= fpu_result_data;
      rd_q[tail_q]   <= fpu_result_rd;
    end
  end

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Scoreboard bench for fpu_wb_buffer: directed scenarios followed by randomized traffic.
module tb_fpu_wb_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic        flush = 1'b0;
  logic        fpu_result_valid = 1'b0;
  logic [31:0] fpu_result_data = '0;
  logic [4:0]  fpu_result_rd = '0;
  logic        alu_wb_active = 1'b0;
  logic        csr_wb_active = 1'b0;
  logic        fpu_complete_rd;
  logic [31:0] fpu_result_rd_w;
  logic [4:0]  fpu_rd_addr;
  logic        fpu_wb_ready;
  logic [31:0] rd_busy;
  logic [3:0]  occupancy;
  logic        overflow_err;

  fpu_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .fpu_result_valid(fpu_result_valid), .fpu_result_data(fpu_result_data),
    .fpu_result_rd(fpu_result_rd), .alu_wb_active(alu_wb_active),
    .csr_wb_active(csr_wb_active), .fpu_complete_rd(fpu_complete_rd),
    .fpu_result_rd_w(fpu_result_rd_w), .fpu_rd_addr(fpu_rd_addr),
    .fpu_wb_ready(fpu_wb_ready), .rd_busy(rd_busy), .occupancy(occupancy),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  r;
  } ent_t;

  ent_t        exp_q[$];
  logic        ovf_m = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] mon_busy;
  logic        mon_strobe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: compares every output against the reference queue once per cycle.
  always @(negedge clk) begin
    if (rst_l) begin
      chk("rst_strobe", 32'(fpu_complete_rd), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_busy", rd_busy, 32'd0);
      chk("rst_ready", 32'(fpu_wb_ready), 32'd1);
      chk("rst_data", fpu_result_rd_w, 32'd0);
      chk("rst_addr", 32'(fpu_rd_addr), 32'd0);
    end else begin
      mon_busy = '0;
      foreach (exp_q[i]) mon_busy[exp_q[i].r] = 1'b1;
      mon_strobe = (exp_q.size() != 0) && !alu_wb_active && !csr_wb_active && !flush;
      chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
      chk("rd_busy", rd_busy, mon_busy);
      chk("ready", 32'(fpu_wb_ready), 32'(exp_q.size() < DEPTH));
      chk("overflow", 32'(overflow_err), 32'(ovf_m));
      chk("strobe", 32'(fpu_complete_rd), 32'(mon_strobe));
      if (exp_q.size() != 0) begin
        chk("head_addr", 32'(fpu_rd_addr), 32'(exp_q[0].r));
        chk("head_data", fpu_result_rd_w, exp_q[0].d);
      end else begin
        chk("empty_addr", 32'(fpu_rd_addr), 32'd0);
        chk("empty_data", fpu_result_rd_w, 32'd0);
      end
      if (mon_strobe) void'(exp_q.pop_front());
    end
  end

  // One clock of stimulus; the reference queue absorbs the effect at the edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic [4:0] r,
                       input logic a, input logic c, input logic f, input logic rs);
    fpu_result_valid = v;
    fpu_result_data  = d;
    fpu_result_rd    = r;
    alu_wb_active    = a;
    csr_wb_active    = c;
    flush            = f;
    rst_l            = rs;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      ovf_m = 1'b0;
    end else if (f) begin
      exp_q.delete();
    end else if (v && r != 5'd0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({d, r});
      else ovf_m = 1'b1;
    end
    #1;
    fpu_result_valid = 1'b0;
    alu_wb_active    = 1'b0;
    csr_wb_active    = 1'b0;
    flush            = 1'b0;
    rst_l            = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic        busy_phase;
  logic [4:0]  r_rand;

  initial begin
    cycle(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single push with port free.
    cycle(1'b1, 32'h3F80_0000, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("single_strobe", 32'(fpu_complete_rd), 32'd1);
    chk("single_addr", 32'(fpu_rd_addr), 32'd5);
    chk("single_data", fpu_result_rd_w, 32'h3F80_0000);
    chk("single_busy", rd_busy, 32'h20);
    idle(1);
    #1;
    chk("single_after_occ", 32'(occupancy), 32'd0);
    chk("single_after_busy", rd_busy, 32'd0);

    // Three pushes under an ALU stall, then a drain with a CSR gap.
    cycle(1'b1, 32'h1111_0003, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h2222_0007, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h3333_0009, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("stall_occ", 32'(occupancy), 32'd3);
    chk("stall_busy", rd_busy, 32'h288);
    idle(1);
    cycle(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Full queue: pop plus push keeps it full, then an overflow drop.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'hA000_0000 + 32'(i), 5'(10 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB000_0000, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fullswap_occ", 32'(occupancy), 32'd4);
    chk("fullswap_ovf", 32'(overflow_err), 32'd0);
    cycle(1'b1, 32'hDEAD_BEEF, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ovf_occ", 32'(occupancy), 32'd4);
    chk("ovf_ready", 32'(fpu_wb_ready), 32'd0);
    chk("ovf_flag", 32'(overflow_err), 32'd1);
    idle(6);

    // rd = 0 is discarded; flush beats a same-cycle push.
    cycle(1'b1, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rd0_occ", 32'(occupancy), 32'd0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'hC000_0000 + 32'(i), 5'(1 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC000_00FF, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_busy", rd_busy, 32'd0);

    // Reset mid-stall discards entries and clears the sticky flag.
    cycle(1'b1, 32'hE000_0001, 5'd30, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hE000_0002, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rstmid_occ", 32'(occupancy), 32'd0);
    chk("rstmid_strobe", 32'(fpu_complete_rd), 32'd0);
    chk("rstmid_ready", 32'(fpu_wb_ready), 32'd1);
    chk("rstmid_ovf", 32'(overflow_err), 32'd0);
    idle(3);

    // Randomized traffic with alternating heavy/light port contention.
    busy_phase = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 40 == 0) busy_phase = ~busy_phase;
      r_rand = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle(1'($urandom_range(0, 1)), $urandom, r_rand,
            busy_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 299) == 0));
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpu_wb_buffer.md
FPU_WB_BUFFER -- requirements
Module: fpu_wb_buffer

Purpose: producer side of the FPU-to-integer-register writeback port. Queues FPU results that target integer rd. Presents them on fpu_complete_rd / fpu_result_rd_w only in cycles when the GPR write port is not claimed by ALU or CSR writeback.

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, 2..8).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_l  input  1  synchronous, active-high reset (asserted = 1, sampled on clk rising edge); name kept for port compatibility.
REQ-004 flush  input  1  discard all queued entries.
REQ-005 fpu_result_valid  input  1  one-cycle strobe: FPU result with integer destination available.
REQ-006 fpu_result_data  input  32  result value.
REQ-007 fpu_result_rd  input  5  destination integer register.
REQ-008 alu_wb_active  input  1  ALU writeback owns GPR port this cycle.
REQ-009 csr_wb_active  input  1  CSR-read writeback owns GPR port this cycle.
REQ-010 fpu_complete_rd  output  1  GPR write strobe for the head entry.
REQ-011 fpu_result_rd_w  output  32  head entry data.
REQ-012 fpu_rd_addr  output  5  head entry destination.
REQ-013 fpu_wb_ready  output  1  queue can accept a push this cycle.
REQ-014 rd_busy  output  32  bit i = 1 while any valid entry targets register i.
REQ-015 occupancy  output  4  number of valid entries.
REQ-016 overflow_err  output  1  sticky: a push was dropped on a full queue.

Function
REQ-017 Storage: circular buffer of DEPTH entries {data[31:0], rd[4:0]} with a head pointer, a tail pointer and a count. Pointers wrap modulo DEPTH.
REQ-018 port_free = ~alu_wb_active & ~csr_wb_active (combinational).
REQ-019 fpu_complete_rd = (count != 0) & port_free & ~flush; purely combinational, same-cycle response to the port-busy inputs.
REQ-020 fpu_result_rd_w and fpu_rd_addr are driven from the head entry whenever count != 0, and are 0 when count == 0.
REQ-021 Pop: occurs in any cycle where fpu_complete_rd = 1; head advances at that clock edge. Each entry is presented with fpu_complete_rd = 1 for exactly one cycle.
REQ-022 Push: occurs when fpu_result_valid = 1, fpu_result_rd != 0, ~flush, and (count < DEPTH or a pop occurs in the same cycle). The entry is written at the tail and the tail advances.
REQ-023 A result with rd = 0 is accepted and discarded. It is not queued and does not raise overflow_err.
REQ-024 Minimum latency: a push in cycle N is visible at the head in cycle N+1 at the earliest; there is no same-cycle bypass.
REQ-025 Push and pop in the same cycle: count is unchanged. This is legal when full and when count = 1.
REQ-026 Push on full without a same-cycle pop: the entry is dropped, overflow_err is set to 1 at the next edge, and queue contents are unchanged.
REQ-027 overflow_err clears only on reset.
REQ-028 fpu_wb_ready = (count < DEPTH), registered-state derived; it does not account for a same-cycle pop.
REQ-029 flush: at the next edge count, head and tail return to 0. Flush overrides a same-cycle push. fpu_complete_rd is forced to 0 in the flush cycle.
REQ-030 rd_busy is a combinational OR over valid entries of one-hot(rd). Duplicate rd values are allowed, and a bit stays set until its last entry pops. rd_busy[0] is always 0.
REQ-031 Entries pop strictly in FIFO order. Port-busy stalls are unbounded, and no entry is ever lost or reordered.

Reset
REQ-032 While rst_l = 1 at an edge: count, head and tail are set to 0 and overflow_err is set to 0; entry storage need not be cleared.
REQ-033 Output values during and after reset: fpu_complete_rd = 0, fpu_result_rd_w = 0, fpu_rd_addr = 0, rd_busy = 0, occupancy = 0, fpu_wb_ready = 1.
REQ-034 Reset takes priority over flush, push and pop. A reset asserted mid-stall discards all entries and emits no write.

Verification
REQ-035 Single push of data 0x3F80_0000, rd = 5, with port free -> next cycle fpu_complete_rd = 1, fpu_rd_addr = 5, fpu_result_rd_w = 0x3F80_0000, rd_busy[5] = 1. The following cycle shows occupancy 0 and rd_busy = 0.
REQ-036 Push rd = 3, 7, 9 while alu_wb_active = 1 for 5 cycles -> no strobes, occupancy = 3, rd_busy = 0x288. After release, strobes occur on three consecutive cycles in order 3, 7, 9. Toggling csr_wb_active in mid-drain inserts gap cycles with no loss.
REQ-037 With DEPTH = 4 and port busy, 5 pushes -> occupancy = 4, fpu_wb_ready = 0, overflow_err = 1, and the 5th value is never emitted.
REQ-038 Full queue with port free plus a same-cycle push -> head pops, new entry accepted, occupancy stays 4, overflow_err stays 0.
REQ-039 Push with rd = 0 -> no strobe and occupancy unchanged. Flush with 3 entries plus a same-cycle push -> next cycle occupancy = 0 and rd_busy = 0.
REQ-040 rst_l = 1 for one edge while 2 entries are queued and the port is busy -> all outputs at reset values next cycle, and no strobe is emitted after the port is released.
